// File: rtl/stack_pkg.sv
// Shared definitions for the tos_stack slice.
//   stack_op_e : operation decoded from {PUSH,POP}; the enum values equal
//                the raw {PUSH,POP} pattern, so decoding is a plain cast.
//   lvl_w()    : width of a counter that can hold 0..depth.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b01,
    OP_REPL = 2'b11
  } stack_op_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage for the entries below the top of stack.
//   DEPTH-1 entries of DATA_SIZE bits; mem[0] is the bottom of the stack.
// Ports:
//   CLK   : clock, write on rising edge
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : asynchronous read index
//   rdata : read data (0 for an index past the end of the array)
// Contents are never reset.
module stack_mem #(
  parameter int DATA_SIZE = 4,
  parameter int DEPTH     = 16,
  parameter int AW        = 4
) (
  input  logic                 CLK,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int N = DEPTH - 1;

  logic [DATA_SIZE-1:0] mem [N];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-power-of-two sizes leave unused address codes; return 0 there.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < N) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/tos_stack.sv
// LIFO stack with a dedicated top-of-stack register.
// Ports:
//   CLK         : clock
//   RST         : synchronous active-high reset
//   CLR         : synchronous clear (empties stack, clears error flags)
//   PUSH, POP   : operation request; both together replace the top entry
//   DATA_WR     : data to push / replace
//   DATA_RD     : registered top of stack, 0 when empty
//   LEVEL       : number of valid entries
//   FULL, EMPTY, ALMOST_FULL : decoded from LEVEL
//   OVF, UNF    : sticky rejected-push / rejected-pop flags
module tos_stack
  import stack_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = DEPTH - 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic                      PUSH,
  input  logic                      POP,
  input  logic [DATA_SIZE-1:0]      DATA_WR,
  output logic [DATA_SIZE-1:0]      DATA_RD,
  output logic [lvl_w(DEPTH)-1:0]   LEVEL,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      ALMOST_FULL,
  output logic                      OVF,
  output logic                      UNF
);

  localparam int LW = lvl_w(DEPTH);
  localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

  stack_op_e            op;
  logic [DATA_SIZE-1:0] tos;
  logic [LW-1:0]        level;
  logic                 ovf;
  logic                 unf;

  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [AW-1:0]        mem_raddr;
  logic [DATA_SIZE-1:0] mem_rdata;

  logic                 is_full;
  logic                 is_empty;

  always_comb begin
    op = stack_op_e'({PUSH, POP});
  end

  always_comb begin
    is_full  = (level == LW'(DEPTH));
    is_empty = (level == '0);
  end

  // Indices are formed at LEVEL width and then narrowed; they are only
  // consumed when LEVEL makes them in range (write: 1..DEPTH-1, read: >=2).
  always_comb begin
    mem_waddr = AW'(level - LW'(1));
    mem_raddr = AW'(level - LW'(2));
    mem_we    = !RST && !CLR && (op == OP_PUSH) && !is_empty && !is_full;
  end

  stack_mem #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (tos),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      tos   <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf <= 1'b1;
          end else begin
            tos   <= DATA_WR;
            level <= level + LW'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf <= 1'b1;
          end else if (level == LW'(1)) begin
            tos   <= '0;
            level <= '0;
          end else begin
            tos   <= mem_rdata;
            level <= level - LW'(1);
          end
        end
        OP_REPL: begin
          // On an empty stack this is a plain push; nothing is written below.
          tos <= DATA_WR;
          if (is_empty) begin
            level <= LW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    DATA_RD     = tos;
    LEVEL       = level;
    FULL        = is_full;
    EMPTY       = is_empty;
    ALMOST_FULL = (level >= LW'(AF_LEVEL));
    OVF         = ovf;
    UNF         = unf;
  end

endmodule
